// File: rtl/hwcnn_pkg.sv
// Shared constants and state encoding for the instruction loader.
package hwcnn_pkg;

  localparam int unsigned INST_LEN     = 160;
  localparam int unsigned DDR_DATA_LEN = 64;
  localparam int unsigned INST_BYTES   = 24;
  localparam int unsigned INST_BEATS   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StConf  = 2'd1,
    StFetch = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_ddr_loader_if.sv
// Host, DDR-FIFO and instruction-buffer signals of the loader; slave is the loader side.
interface inst_ddr_loader_if #(
  parameter int unsigned INST_LEN     = hwcnn_pkg::INST_LEN,
  parameter int unsigned DDR_DATA_LEN = hwcnn_pkg::DDR_DATA_LEN,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24
);

  logic                    start;
  logic [SINGLE_LEN-1:0]   inst_num;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    ddr_fifo_empty;
  logic                    ddr_fifo_req;
  logic [DDR_DATA_LEN-1:0] ddr_fifo_data;
  logic [INST_LEN-1:0]     instruct;
  logic                    inst_empty;
  logic                    inst_req;
  logic                    idle;

  modport slave (
    input  start, inst_num, ddr_st_addr, ddr_fifo_empty, ddr_fifo_data, inst_req,
    output ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req, instruct, inst_empty, idle
  );

  modport master (
    output start, inst_num, ddr_st_addr, ddr_fifo_empty, ddr_fifo_data, inst_req,
    input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req, instruct, inst_empty, idle
  );

endinterface

// File: rtl/inst_sync_fifo.sv
// First-word-fall-through instruction buffer with registered count, empty and full.
module inst_sync_fifo #(
  parameter int unsigned WIDTH = 160,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_empty, r_full;
  logic             w_push, w_pop;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CNT_W'(1);
      2'b01:   w_count_d = r_count - CNT_W'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_d;
      r_empty <= (w_count_d == '0);
      r_full  <= (w_count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/inst_ddr_loader.sv
// Requests a block of instructions from DDR, packs 64-bit beats into instructions
// and queues them in a first-word-fall-through buffer.
module inst_ddr_loader #(
  parameter int unsigned INST_LEN     = hwcnn_pkg::INST_LEN,
  parameter int unsigned DDR_DATA_LEN = hwcnn_pkg::DDR_DATA_LEN,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned INST_DEPTH   = 32
) (
  input logic               clk,
  input logic               rst_n,
  inst_ddr_loader_if.slave  bus
);

  import hwcnn_pkg::*;

  localparam int unsigned CNT_W   = $clog2(INST_DEPTH) + 1;
  localparam int unsigned LO_W    = 2 * DDR_DATA_LEN;
  localparam int unsigned TAIL_W  = INST_LEN - LO_W;
  localparam logic [1:0] BEAT_LAST = 2'(INST_BEATS - 1);

  ld_state_e               r_state;
  logic                    r_idle, r_conf;
  logic [DDR_ADDR_LEN-1:0] r_addr;
  logic [SINGLE_LEN-1:0]   r_len, r_num, r_done;
  logic [1:0]              r_beat;
  logic [LO_W-1:0]         r_lo;

  logic [CNT_W-1:0]        w_count;
  logic                    w_req, w_last_beat;
  logic [INST_LEN-1:0]     w_wr_data;

  assign w_req = (r_state == StFetch) && !bus.ddr_fifo_empty &&
                 (w_count < CNT_W'(INST_DEPTH));
  assign w_last_beat = w_req && (r_beat == BEAT_LAST);
  // Upper half of the final beat carries no instruction bits.
  assign w_wr_data = {bus.ddr_fifo_data[TAIL_W-1:0], r_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idle  <= 1'b1;
      r_conf  <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_num   <= '0;
      r_done  <= '0;
      r_beat  <= '0;
      r_lo    <= '0;
    end else begin
      r_conf <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start && (bus.inst_num != '0)) begin
            r_num   <= bus.inst_num;
            r_addr  <= bus.ddr_st_addr;
            r_len   <= bus.inst_num * SINGLE_LEN'(INST_BYTES);
            r_conf  <= 1'b1;
            r_idle  <= 1'b0;
            r_done  <= '0;
            r_beat  <= '0;
            r_state <= StConf;
          end
        end
        StConf: r_state <= StFetch;
        StFetch: begin
          if (w_req) begin
            if (r_beat == BEAT_LAST) begin
              r_beat <= '0;
              r_done <= r_done + SINGLE_LEN'(1);
              if (r_done == r_num - SINGLE_LEN'(1)) begin
                r_state <= StIdle;
                r_idle  <= 1'b1;
              end
            end else begin
              if (r_beat == 2'd0) r_lo[DDR_DATA_LEN-1:0]    <= bus.ddr_fifo_data;
              else                r_lo[LO_W-1:DDR_DATA_LEN] <= bus.ddr_fifo_data;
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  inst_sync_fifo #(
    .WIDTH (INST_LEN),
    .DEPTH (INST_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_last_beat),
    .i_wr_data (w_wr_data),
    .i_rd_en   (bus.inst_req),
    .o_rd_data (bus.instruct),
    .o_empty   (bus.inst_empty),
    .o_count   (w_count)
  );

  assign bus.ddr_st_addr_out = r_addr;
  assign bus.ddr_len         = r_len;
  assign bus.ddr_conf        = r_conf;
  assign bus.ddr_fifo_req    = w_req;
  assign bus.idle            = r_idle;

endmodule

// File: tb/tb_inst_ddr_loader.sv
// Directed bench for inst_ddr_loader with a queue-based DDR FIFO model.
module tb_inst_ddr_loader;

  localparam int unsigned INST_LEN     = 160;
  localparam int unsigned DDR_DATA_LEN = 64;
  localparam int unsigned DDR_ADDR_LEN = 32;
  localparam int unsigned SINGLE_LEN   = 24;
  localparam int unsigned INST_DEPTH   = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_ddr_loader_if #(
    .INST_LEN     (INST_LEN),
    .DDR_DATA_LEN (DDR_DATA_LEN),
    .DDR_ADDR_LEN (DDR_ADDR_LEN),
    .SINGLE_LEN   (SINGLE_LEN)
  ) bus ();

  inst_ddr_loader #(
    .INST_LEN     (INST_LEN),
    .DDR_DATA_LEN (DDR_DATA_LEN),
    .DDR_ADDR_LEN (DDR_ADDR_LEN),
    .SINGLE_LEN   (SINGLE_LEN),
    .INST_DEPTH   (INST_DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int pops = 0;
  int viol = 0;
  int conf_cnt = 0;
  bit rand_en = 1'b0;
  logic [31:0]  conf_addr = '0;
  logic [23:0]  conf_len = '0;
  logic [63:0]  ddr_q [$];
  logic [159:0] exp_q [$];

  // DDR FIFO model: consume on req at the edge, present the new head just after it.
  always @(posedge clk) begin
    logic [63:0] dropped;
    if (bus.ddr_fifo_req) begin
      pops++;
      if (bus.ddr_fifo_empty || ddr_q.size() == 0) viol++;
      else dropped = ddr_q.pop_front();
    end
    if (bus.ddr_conf) begin
      conf_cnt++;
      conf_addr = bus.ddr_st_addr_out;
      conf_len  = bus.ddr_len;
    end
    #1;
    bus.ddr_fifo_empty = (ddr_q.size() == 0) || (rand_en && ($urandom_range(0, 1) == 1));
    bus.ddr_fifo_data  = (ddr_q.size() != 0) ? ddr_q[0] : '0;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] beat(input int k, input int j);
    return {12'hB00, 4'(j), 16'(k), 16'(16'h1111 * j), 16'(k * 7 + j + 1)};
  endfunction

  function automatic logic [159:0] inst_of(input int k);
    logic [63:0] b2;
    b2 = beat(k, 2);
    return {b2[31:0], beat(k, 1), beat(k, 0)};
  endfunction

  task automatic push_inst(input int k);
    for (int j = 0; j < 3; j++) ddr_q.push_back(beat(k, j));
    exp_q.push_back(inst_of(k));
  endtask

  task automatic start_load(input int n, input logic [31:0] addr);
    bus.start = 1'b1;
    bus.inst_num = 24'(n);
    bus.ddr_st_addr = addr;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i = 0;
    while (!bus.idle && i < bound) begin
      tick();
      i++;
    end
    check(tag, 160'(bus.idle), 160'(1));
  endtask

  task automatic wait_pops(input string tag, input int n, input int bound);
    int i = 0;
    while (pops < n && i < bound) begin
      tick();
      i++;
    end
    check(tag, 160'(pops), 160'(n));
  endtask

  task automatic pop_expect(input string tag);
    check(tag, bus.instruct, exp_q.pop_front());
    bus.inst_req = 1'b1;
    tick();
    bus.inst_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_idle"},  160'(bus.idle), 160'(1));
    check({tag, "_conf"},  160'(bus.ddr_conf), 160'(0));
    check({tag, "_req"},   160'(bus.ddr_fifo_req), 160'(0));
    check({tag, "_addr"},  160'(bus.ddr_st_addr_out), 160'(0));
    check({tag, "_len"},   160'(bus.ddr_len), 160'(0));
    check({tag, "_empty"}, 160'(bus.inst_empty), 160'(1));
    check({tag, "_inst"},  bus.instruct, 160'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.inst_num = '0;
    bus.ddr_st_addr = '0;
    bus.inst_req = 1'b0;
    bus.ddr_fifo_empty = 1'b1;
    bus.ddr_fifo_data = '0;

    tick();
    tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Zero-length start is ignored.
    start_load(0, 32'h2000);
    tick();
    tick();
    check("zero_idle", 160'(bus.idle), 160'(1));
    check("zero_conf", 160'(conf_cnt), 160'(0));

    // Four instructions, the first with hand-written beats.
    pops = 0;
    ddr_q.push_back(64'h1111111111111111);
    ddr_q.push_back(64'h2222222222222222);
    ddr_q.push_back(64'hAABBCCDD33333333);
    exp_q.push_back(160'h33333333_2222222222222222_1111111111111111);
    for (int k = 1; k < 4; k++) push_inst(k);
    tick();
    start_load(4, 32'h1000);
    wait_idle("t4_idle", 60);
    check("t4_pops", 160'(pops), 160'(12));
    check("t4_conf_cnt", 160'(conf_cnt), 160'(1));
    check("t4_addr", 160'(conf_addr), 160'(32'h1000));
    check("t4_len", 160'(conf_len), 160'(96));
    check("t4_head", bus.instruct, 160'h33333333_2222222222222222_1111111111111111);
    for (int k = 0; k < 4; k++) pop_expect("t4_inst");
    check("t4_drained", 160'(bus.inst_empty), 160'(1));

    // Randomly stalling DDR FIFO.
    pops = 0;
    viol = 0;
    rand_en = 1'b1;
    push_inst(10);
    push_inst(11);
    start_load(2, 32'h40);
    wait_idle("rnd_idle", 200);
    rand_en = 1'b0;
    check("rnd_pops", 160'(pops), 160'(6));
    check("rnd_req_empty", 160'(viol), 160'(0));
    check("rnd_len", 160'(conf_len), 160'(48));
    pop_expect("rnd_inst0");
    pop_expect("rnd_inst1");

    // Buffer fills to depth, then drains and refills.
    pops = 0;
    viol = 0;
    for (int k = 20; k < 60; k++) push_inst(k);
    start_load(40, 32'h8000);
    start_load(3, 32'hDEAD0000);
    repeat (150) tick();
    check("full_pops", 160'(pops), 160'(96));
    check("full_busy", 160'(bus.idle), 160'(0));
    check("full_conf_cnt", 160'(conf_cnt), 160'(3));
    for (int k = 0; k < 8; k++) pop_expect("full_pop8");
    wait_idle("full_idle", 100);
    check("full_pops_all", 160'(pops), 160'(120));
    check("full_viol", 160'(viol), 160'(0));
    check("full_len", 160'(conf_len), 160'(960));
    for (int k = 0; k < 32; k++) pop_expect("full_drain");
    check("full_drained", 160'(bus.inst_empty), 160'(1));

    // Pop request on an empty buffer.
    bus.inst_req = 1'b1;
    tick();
    bus.inst_req = 1'b0;
    check("epop_empty", 160'(bus.inst_empty), 160'(1));
    check("epop_inst", bus.instruct, 160'(0));
    check("epop_idle", 160'(bus.idle), 160'(1));

    // Simultaneous write and pop at five entries.
    pops = 0;
    for (int k = 70; k < 75; k++) push_inst(k);
    start_load(5, 32'h600);
    wait_idle("pp_idle5", 60);
    ddr_q.push_back(beat(75, 0));
    ddr_q.push_back(beat(75, 1));
    exp_q.push_back(inst_of(75));
    start_load(1, 32'h700);
    wait_pops("pp_two_beats", 17, 30);
    ddr_q.push_back(beat(75, 2));
    tick();
    pop_expect("pp_same_edge");
    check("pp_idle", 160'(bus.idle), 160'(1));
    for (int k = 0; k < 5; k++) pop_expect("pp_drain");
    check("pp_drained", 160'(bus.inst_empty), 160'(1));

    // Reset after beat1 of the second instruction.
    pops = 0;
    push_inst(80);
    ddr_q.push_back(beat(81, 0));
    ddr_q.push_back(beat(81, 1));
    start_load(3, 32'h3000);
    wait_pops("mid_pops", 5, 30);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    ddr_q.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    pops = 0;
    push_inst(90);
    start_load(1, 32'h5000);
    wait_idle("post_idle", 40);
    check("post_pops", 160'(pops), 160'(3));
    check("post_addr", 160'(conf_addr), 160'(32'h5000));
    check("post_len", 160'(conf_len), 160'(24));
    pop_expect("post_inst");
    check("post_drained", 160'(bus.inst_empty), 160'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_ddr_loader.md
INST_DDR_LOADER -- requirements
Module: inst_ddr_loader

Interface
REQ-001 SHALL have parameter INST_LEN, default 160, instruction width in bits.
REQ-002 SHALL have parameter DDR_DATA_LEN, default 64, DDR FIFO beat width.
REQ-003 SHALL have parameter DDR_ADDR_LEN, default 32, DDR byte-address width.
REQ-004 SHALL have parameter SINGLE_LEN, default 24, count/length field width.
REQ-005 SHALL have parameter INST_DEPTH, default 32 (power of two), instruction-buffer entries.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports start in 1 (load pulse), inst_num in SINGLE_LEN (instructions to fetch), ddr_st_addr in DDR_ADDR_LEN (first byte address).
REQ-009 SHALL have ports ddr_st_addr_out out DDR_ADDR_LEN, ddr_len out SINGLE_LEN (bytes), ddr_conf out 1 (request strobe).
REQ-010 SHALL have ports ddr_fifo_empty in 1, ddr_fifo_req out 1 (pop), ddr_fifo_data in DDR_DATA_LEN (first-word-fall-through head).
REQ-011 SHALL have ports instruct out INST_LEN (buffer head), inst_empty out 1, inst_req in 1 (pop), idle out 1.

Function
REQ-012 SHALL implement FSM IDLE -> CONF -> FETCH -> IDLE; idle=1 only in IDLE.
REQ-013 IDLE: start=1 with inst_num!=0 SHALL latch inputs and go to CONF; start with inst_num=0 SHALL be ignored.
REQ-014 CONF: ddr_conf=1 for exactly one cycle, ddr_st_addr_out=latched address, ddr_len=inst_num*24 (truncated to SINGLE_LEN); next state FETCH.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 Each instruction SHALL occupy 3 beats: beat0 -> bits[63:0], beat1 -> [127:64], beat2 low 32 bits -> [159:128]; beat2 upper 32 bits discarded.
REQ-017 FETCH: ddr_fifo_req=1 iff !ddr_fifo_empty and instruction buffer not full (registered count<INST_DEPTH); data consumed same cycle as req.
REQ-018 On beat2 pop the assembled instruction SHALL be written into the buffer that same edge; beat counter wraps 2->0.
REQ-019 FETCH SHALL return to IDLE on the edge that writes the inst_num-th instruction; ddr_fifo_req=0 from then.
REQ-020 Buffer SHALL be first-word-fall-through: instruct=head whenever inst_empty=0; inst_req pops on that edge; read-to-write independent.
REQ-021 inst_req while inst_empty=1 SHALL be ignored; simultaneous write and pop SHALL keep count unchanged.
REQ-022 inst_empty SHALL be registered, 1 when count=0; a written instruction SHALL appear at instruct with inst_empty=0 one cycle after the write edge.
REQ-023 Pointers SHALL wrap modulo INST_DEPTH; count width log2(INST_DEPTH)+1.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM IDLE, idle=1, ddr_conf=0, ddr_fifo_req=0, ddr_st_addr_out=0, ddr_len=0, inst_empty=1, instruct=0, pointers/count/beat counter=0.
REQ-025 Reset mid-FETCH SHALL discard partial instruction and buffered contents; no recovery of upstream DDR FIFO state is required.

Structure
REQ-026 Constants INST_LEN, DDR_DATA_LEN, bytes-per-instruction (24), beats-per-instruction (3) and FSM state encoding SHALL live in shared package hwcnn_pkg.
REQ-027 Buffer SHALL be a separate sub-module inst_sync_fifo (FWFT, registered count/empty/full); loader FSM and beat packer in top.

Verification
REQ-028 start, inst_num=4, ddr_st_addr=0x1000, 12 beats ready -> one ddr_conf pulse, ddr_len=96, addr 0x1000; 4 instructions in order; idle=1 after 4th write.
REQ-029 Beats 0x11..11,0x22..22,0xAABBCCDD_33333333 -> instruct=0x33333333_2222222222222222_1111111111111111.
REQ-030 inst_num=40, inst_req held 0 -> exactly 96 pops, ddr_fifo_req=0 while full; after 8 inst_req pops remaining 8 fetched, final count 32.
REQ-031 ddr_fifo_empty toggled randomly mid-instruction -> correct packing, no req while empty.
REQ-032 inst_req with inst_empty=1 -> no state change; push+pop same cycle at count=5 -> count stays 5.
REQ-033 rst_n=0 after beat1 of instruction 2 -> all REQ-024 values within same cycle; new start fetches cleanly from beat0.
